// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, results held until the next start.
// A zero divisor skips the iteration and returns all-ones quotient with the dividend as remainder.
module seq_divider #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LastStep = CW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_nx;
  logic [WIDTH-1:0] dvd_nx;

  // One restoring step; the extra remainder bit keeps compare/subtract overflow-free.
  always_comb begin
    rem_sh = (rem_q << 1) | {{WIDTH{1'b0}}, dvd_q[WIDTH-1]};
    dvd_nx = {dvd_q[WIDTH-2:0], 1'b0};
    rem_nx = rem_sh;
    if (rem_sh >= {1'b0, dvs_q}) begin
      rem_nx    = rem_sh - {1'b0, dvs_q};
      dvd_nx[0] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rem_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            dvd_q <= dividend;
            dvs_q <= divisor;
            rem_q <= '0;
            cnt_q <= '0;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state_q     <= StDone;
            end else begin
              div_by_zero <= 1'b0;
              busy        <= 1'b1;
              state_q     <= StRun;
            end
          end
        end
        StRun: begin
          rem_q <= rem_nx;
          dvd_q <= dvd_nx;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LastStep) begin
            quotient  <= dvd_nx;
            remainder <= rem_nx[WIDTH-1:0];
            busy      <= 1'b0;
            done      <= 1'b1;
            state_q   <= StDone;
          end
        end
        StDone: begin
          done    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning the operand and result bit width (legal range 2..16).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request a division; sampled only in IDLE.
REQ-005 The block SHALL have port dividend, input, WIDTH bits: unsigned numerator, captured when start is accepted.
REQ-006 The block SHALL have port divisor, input, WIDTH bits: unsigned denominator, captured when start is accepted.
REQ-007 The block SHALL have port busy, output, 1 bit: high while in RUN.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse marking that the results are valid.
REQ-009 The block SHALL have port quotient, output, WIDTH bits: registered result.
REQ-010 The block SHALL have port remainder, output, WIDTH bits: registered result.
REQ-011 The block SHALL have port div_by_zero, output, 1 bit: error flag qualifying the current results.

Function
REQ-012 The block SHALL implement an FSM with states IDLE, RUN and DONE, all outputs registered.
REQ-013 In IDLE with start=1 and divisor!=0 at edge k, the block SHALL capture the operands, clear the partial remainder and iteration counter, and enter RUN.
REQ-014 In RUN, the block SHALL perform one restoring-division step per cycle:
- shift {rem, dvd} left by 1;
- if rem >= divisor, subtract divisor and set the quotient LSB to 1, else set it to 0.
REQ-015 The partial remainder SHALL be WIDTH+1 bits internally so that the compare and subtract never overflow.
REQ-016 After exactly WIDTH RUN steps (edges k+1..k+WIDTH), the block SHALL enter DONE, load quotient/remainder, and drive done=1 and busy=0 after edge k+WIDTH.
REQ-017 From DONE, the block SHALL return unconditionally to IDLE on the next edge, with done=0.
REQ-018 quotient, remainder and div_by_zero SHALL hold their values until the next accepted start or reset.
REQ-019 start SHALL be ignored in RUN and DONE; operand changes during RUN SHALL not affect the result.
REQ-020 In IDLE with start=1 and divisor==0 at edge k, the block SHALL skip RUN, enter DONE directly, and set quotient={WIDTH{1}}, remainder=dividend, div_by_zero=1.
REQ-021 div_by_zero SHALL be cleared on every accepted start with divisor!=0.
REQ-022 Results SHALL equal integer dividend/divisor and dividend%divisor for all nonzero divisors, including dividend<divisor (quotient 0, remainder dividend) and dividend==divisor (quotient 1, remainder 0).
REQ-023 start held high continuously SHALL launch back-to-back operations, one every WIDTH+2 cycles (IDLE sample, WIDTH RUN cycles, DONE).

Reset
REQ-024 When rst_n=0, the block SHALL immediately (without a clock edge) force state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, and clear the internal counter and registers.
REQ-025 When reset is asserted mid-RUN, the block SHALL abort the operation with no done pulse; the first start after rst_n rises SHALL behave as from power-up.
REQ-026 While rst_n=0, the block SHALL accept no start.

Verification (WIDTH=4)
REQ-027 The bench SHALL apply dividend=13, divisor=3, start at edge k and check: busy=1 for edges k+1..k+4; done=1 after edge k+4 with quotient=4, remainder=1, div_by_zero=0.
REQ-028 The bench SHALL apply 15/1 and check quotient=15, remainder=0; and apply 2/7 and check quotient=0, remainder=2, each with done after 4 RUN cycles.
REQ-029 The bench SHALL apply 9/0 and check that done=1 after edge k (no busy), quotient=15, remainder=9, div_by_zero=1; a following 8/2 SHALL give quotient=4, remainder=0, div_by_zero=0.
REQ-030 The bench SHALL start 12/5, then change the operands to 7/7 and pulse start mid-RUN, and check that the result is quotient=2, remainder=2 with exactly one done pulse.
REQ-031 The bench SHALL assert rst_n=0 two cycles into a RUN and check that all outputs go to 0 asynchronously and no done pulse follows; after release, 6/4 SHALL give quotient=1, remainder=2.
REQ-032 The bench SHALL run all 256 dividend/divisor pairs and compare against the / and % operators, expecting the REQ-020 values for divisor 0, and SHALL report any mismatch.
